bell_round_ctrl: RTL

//  Round sequencer and bell arbiter for the two-player card/bell game.

---
 rtl/bell_round_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bell_round_ctrl.sv
// ---------------------------------------------------------------------------
// bell_round_ctrl
//   Round sequencer and bell arbiter for the two-player card/bell game.
//   It requests a card pair, shows it for SHOW_CYC cycles, and accepts the
//   first bell press. The press is judged with the external match checker,
//   and exactly one score update is emitted per accepted press. It also
//   declares a winner from the running totals held in the score file.
//
//   Optional feature: define BELL_LOCKOUT_EN to lock out a player whose
//   press was judged wrong. The lock lasts until the next correct press.
//   If both players are locked, both locks are cleared at the next deal.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   start           one-cycle pulse, starts a game from IDLE or OVER
//   keypad_in/_vld  key code with a one-cycle qualifier
//   card_ready      new card pair is valid
//   match           combinational match result for the current pair
//   total_a/_b      9-bit two's complement totals from the score file
//   card_req        one-cycle pulse requesting the next pair
//   score_clr       one-cycle pulse clearing the score file
//   add_vld/a/b     one-cycle score update, 8-bit two's complement deltas
//   bell_owner      01=A, 10=B, 00=none (latched press owner)
//   round_cnt       pairs dealt in this game
//   game_over       high in OVER
//   winner          01=A, 10=B, 11=draw, 00=none
// ---------------------------------------------------------------------------
module bell_round_ctrl #(
   parameter int         SHOW_CYC   = 1000,
   parameter int         WIN_MARGIN = 50,
   parameter int         MAX_ROUNDS = 64,
   parameter logic [3:0] KEY_P1     = 4'h7,
   parameter logic [3:0] KEY_P2     = 4'h9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] keypad_in,
   input  logic       keypad_vld,
   input  logic       card_ready,
   input  logic       match,
   input  logic [8:0] total_a,
   input  logic [8:0] total_b,
   output logic       card_req,
   output logic       score_clr,
   output logic       add_vld,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic [1:0] bell_owner,
   output logic [6:0] round_cnt,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int TW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
   localparam logic [TW-1:0]     T_LAST     = TW'(SHOW_CYC - 1);
   localparam logic signed [9:0] MARGIN     = 10'(WIN_MARGIN);
   localparam logic signed [9:0] NEG_MARGIN = 10'(-WIN_MARGIN);

   typedef enum logic [2:0] {
      S_IDLE, S_DEAL, S_SHOW, S_JUDGE, S_SCORE, S_SETTLE, S_CHECK, S_OVER
   } state_t;

   state_t state, state_d;

   logic [TW-1:0]     timer;
   logic [6:0]        pot;
   logic              match_q;
   logic              deal_first;
   logic              lock_a, lock_b;
   logic              press_a, press_b;
   logic              go_start, take_card, take_press, enter_deal;
   logic signed [9:0] diff;
   logic              lead_a, lead_b, last_round;
   logic [1:0]        winner_d;
   logic [7:0]        pot_ext;

   assign pot_ext = {1'b0, pot};

   // A press counts only if the player is not locked out.
   assign press_a = keypad_vld && (keypad_in == KEY_P1) && !lock_a;
   assign press_b = keypad_vld && (keypad_in == KEY_P2) && !lock_b;

   // Sign-extend both totals before subtracting so the difference cannot wrap.
   assign diff       = {total_a[8], total_a} - {total_b[8], total_b};
   assign lead_a     = diff > MARGIN;
   assign lead_b     = diff < NEG_MARGIN;
   assign last_round = round_cnt == 7'(MAX_ROUNDS);

   always_comb begin
      winner_d = 2'b00;
      if (lead_a)           winner_d = 2'b01;
      else if (lead_b)      winner_d = 2'b10;
      else if (last_round) begin
         if (diff > 10'sd0)      winner_d = 2'b01;
         else if (diff < 10'sd0) winner_d = 2'b10;
         else                    winner_d = 2'b11;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   // Next state and strobes
   always_comb begin
      state_d    = state;
      go_start   = 1'b0;
      take_card  = 1'b0;
      take_press = 1'b0;
      card_req   = 1'b0;
      add_vld    = 1'b0;
      game_over  = 1'b0;
      case (state)
         S_IDLE: if (start) begin
            state_d  = S_DEAL;
            go_start = 1'b1;
         end
         S_DEAL: begin
            card_req = deal_first;
            if (card_ready) begin
               state_d   = S_SHOW;
               take_card = 1'b1;
            end
         end
         S_SHOW: begin
            // A press in the timeout cycle still wins.
            if (press_a || press_b) begin
               state_d    = S_JUDGE;
               take_press = 1'b1;
            end else if (timer == T_LAST) begin
               state_d = S_CHECK;
            end
         end
         S_JUDGE:  state_d = S_SCORE;
         S_SCORE: begin
            add_vld = 1'b1;
            state_d = S_SETTLE;
         end
         S_SETTLE: state_d = S_CHECK;
         S_CHECK:  state_d = (winner_d != 2'b00) ? S_OVER : S_DEAL;
         S_OVER: begin
            game_over = 1'b1;
            if (start) begin
               state_d  = S_DEAL;
               go_start = 1'b1;
            end
         end
         default:  state_d = S_IDLE;
      endcase
      enter_deal = (state_d == S_DEAL) && (state != S_DEAL);
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         score_clr  <= 1'b0;
         deal_first <= 1'b0;
         round_cnt  <= 7'd0;
         pot        <= 7'd0;
         timer      <= '0;
         bell_owner <= 2'b00;
         match_q    <= 1'b0;
         add_a      <= 8'd0;
         add_b      <= 8'd0;
         winner     <= 2'b00;
      end else begin
         score_clr  <= go_start;
         deal_first <= enter_deal;   // card_req only in the first DEAL cycle
         if (go_start) begin
            round_cnt <= 7'd0;
            pot       <= 7'd0;
            winner    <= 2'b00;
         end
         if (enter_deal) bell_owner <= 2'b00;
         if (take_card) begin
            round_cnt <= round_cnt + 7'd1;
            if (pot != 7'h7F) pot <= pot + 7'd1;
            timer <= '0;
         end else if (state == S_SHOW) begin
            timer <= timer + TW'(1);
         end
         if (take_press) begin
            bell_owner <= press_a ? 2'b01 : 2'b10;
            match_q    <= match;
         end
         if (state == S_JUDGE) begin
            if (match_q) begin
               add_a <= bell_owner[0] ? pot_ext : 8'd0;
               add_b <= bell_owner[1] ? pot_ext : 8'd0;
               pot   <= 7'd0;
            end else begin
               add_a <= bell_owner[0] ? 8'hFF : 8'h01;
               add_b <= bell_owner[1] ? 8'hFF : 8'h01;
            end
         end
         if (state == S_CHECK && state_d == S_OVER) winner <= winner_d;
      end
   end

`ifdef BELL_LOCKOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_a <= 1'b0;
         lock_b <= 1'b0;
      end else if (go_start) begin
         lock_a <= 1'b0;
         lock_b <= 1'b0;
      end else if (state == S_JUDGE) begin
         if (match_q) begin
            lock_a <= 1'b0;
            lock_b <= 1'b0;
         end else begin
            if (bell_owner[0]) lock_a <= 1'b1;
            if (bell_owner[1]) lock_b <= 1'b1;
         end
      end else if (enter_deal && lock_a && lock_b) begin
         // If both players are locked, nobody could ring, so release both.
         lock_a <= 1'b0;
         lock_b <= 1'b0;
      end
   end
`else
   assign lock_a = 1'b0;
   assign lock_b = 1'b0;
`endif

endmodule
